// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, 32x32 register file with write-through bypass, immediate extend, load-use detect.
// Latency: one cycle from fetch inputs to outputs; register-file reads are combinational off the IF/ID register.
// Backpressure: stall_in or a load-use hazard holds IF/ID (hazard also bubbles execute); flush_in squashes and wins over stalls.
module decode_stage #(
   parameter int                  W_BUNDLE   = 24,
   parameter logic [31:0]         RESET_PC   = 32'h0040_0000,
   parameter logic [31:0]         NOP_INSTR  = 32'h3400_0000,
   parameter logic [W_BUNDLE-1:0] NOP_BUNDLE = 24'h0E2531
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         instruction_in,
   input  logic [W_BUNDLE-1:0] bundle_in,
   input  logic [31:0]         pc_seq_in,
   input  logic                stall_in,
   input  logic                flush_in,
   input  logic                wb_we_in,
   input  logic [4:0]          wb_addr_in,
   input  logic [31:0]         wb_data_in,
   input  logic                ex_load_in,
   input  logic [4:0]          ex_dest_in,
   output logic [31:0]         instruction_out,
   output logic [W_BUNDLE-1:0] bundle_out,
   output logic [31:0]         pc_seq_out,
   output logic [31:0]         rs_data_out,
   output logic [31:0]         rt_data_out,
   output logic [31:0]         imm_out,
   output logic                hazard_stall_out,
   output logic                valid_out
);

   logic [31:0]         instr_q;
   logic [W_BUNDLE-1:0] bundle_q;
   logic [31:0]         pc_seq_q;
   logic                valid_q;
   logic [31:0]         rf [32];

   logic [5:0] opcode;
   logic [4:0] rs_addr;
   logic [4:0] rt_addr;
   logic       uses_rt;
   logic       hazard;

   assign opcode  = instr_q[31:26];
   assign rs_addr = instr_q[25:21];
   assign rt_addr = instr_q[20:16];

   // IF/ID register: reset, then flush (squash), then hold on any stall, else load from fetch
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q  <= NOP_INSTR;
         bundle_q <= NOP_BUNDLE;
         pc_seq_q <= RESET_PC;
         valid_q  <= 1'b0;
      end else if (flush_in) begin
         instr_q  <= NOP_INSTR;
         bundle_q <= NOP_BUNDLE;
         valid_q  <= 1'b0;
      end else if (!(stall_in || hazard)) begin
         instr_q  <= instruction_in;
         bundle_q <= bundle_in;
         pc_seq_q <= pc_seq_in;
         valid_q  <= 1'b1;
      end
   end

   // Register file write port; $0 is never written so it always reads back zero
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_we_in && (wb_addr_in != 5'd0)) begin
         rf[wb_addr_in] <= wb_data_in;
      end
   end

   // Read ports with same-cycle bypass of the writeback value
   always_comb begin
      rs_data_out = '0;
      rt_data_out = '0;
      if (rs_addr != 5'd0) begin
         if (wb_we_in && (wb_addr_in == rs_addr)) rs_data_out = wb_data_in;
         else                                     rs_data_out = rf[rs_addr];
      end
      if (rt_addr != 5'd0) begin
         if (wb_we_in && (wb_addr_in == rt_addr)) rt_data_out = wb_data_in;
         else                                     rt_data_out = rf[rt_addr];
      end
   end

   // Load-use detection: rt only counts for R-type, branches and stores
   always_comb begin
      uses_rt = 1'b0;
      case (opcode)
         6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: uses_rt = 1'b1;
         default:                                  uses_rt = 1'b0;
      endcase
      hazard = ex_load_in && valid_q && (ex_dest_in != 5'd0) &&
               ((ex_dest_in == rs_addr) || (uses_rt && (ex_dest_in == rt_addr)));
   end

   // Execute-facing outputs: a hazard replaces the held instruction with a bubble
   always_comb begin
      instruction_out  = hazard ? NOP_INSTR : instr_q;
      bundle_out       = hazard ? NOP_BUNDLE : bundle_q;
      pc_seq_out       = pc_seq_q;
      valid_out        = valid_q;
      hazard_stall_out = hazard;
      imm_out          = bundle_q[19] ? {16'h0000, instr_q[15:0]}
                                      : {{16{instr_q[15]}}, instr_q[15:0]};
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, IF/ID latency, register-file bypass, load-use bubbling, flush/stall, immediate extend.
// Inputs change #1 after the rising edge; outputs are sampled in the same window.
// Each scenario task checks its own expectations and updates the shared counters.
module tb_decode_stage;

   localparam logic [31:0] NOP_I = 32'h3400_0000;
   localparam logic [23:0] NOP_B = 24'h0E2531;
   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction_in;
   logic [23:0] bundle_in;
   logic [31:0] pc_seq_in;
   logic        stall_in, flush_in, wb_we_in, ex_load_in;
   logic [4:0]  wb_addr_in, ex_dest_in;
   logic [31:0] wb_data_in;
   logic [31:0] instruction_out, pc_seq_out, rs_data_out, rt_data_out, imm_out;
   logic [23:0] bundle_out;
   logic        hazard_stall_out, valid_out;

   int checks = 0;
   int errors = 0;

   decode_stage dut (
      .clk(clk), .reset(reset),
      .instruction_in(instruction_in), .bundle_in(bundle_in), .pc_seq_in(pc_seq_in),
      .stall_in(stall_in), .flush_in(flush_in),
      .wb_we_in(wb_we_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
      .ex_load_in(ex_load_in), .ex_dest_in(ex_dest_in),
      .instruction_out(instruction_out), .bundle_out(bundle_out), .pc_seq_out(pc_seq_out),
      .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
      .hazard_stall_out(hazard_stall_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] ins, input logic [23:0] bun, input logic [31:0] pc);
      instruction_in = ins;
      bundle_in      = bun;
      pc_seq_in      = pc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      present(32'h0, 24'h0, 32'h0);
      stall_in = 0; flush_in = 0; wb_we_in = 0; wb_addr_in = 0; wb_data_in = 0;
      ex_load_in = 0; ex_dest_in = 0;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (instruction_out !== NOP_I) begin errors++; $display("FAIL reset_instr: got %h expected %h", instruction_out, NOP_I); end
      checks++; if (bundle_out !== NOP_B) begin errors++; $display("FAIL reset_bundle: got %h expected %h", bundle_out, NOP_B); end
      checks++; if (pc_seq_out !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_seq_out, RST_PC); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
      checks++; if (hazard_stall_out !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall_out); end
      checks++; if (imm_out !== 32'h0) begin errors++; $display("FAIL reset_imm: got %h expected 0", imm_out); end
      checks++; if (rs_data_out !== 32'h0 || rt_data_out !== 32'h0) begin errors++; $display("FAIL reset_rf: got rs=%h rt=%h expected 0", rs_data_out, rt_data_out); end
   endtask

   task automatic test_latency();
      present(32'h8C88_0004, 24'h000005, 32'h0040_0004);
      tick();
      checks++; if (instruction_out !== 32'h8C88_0004) begin errors++; $display("FAIL lw_instr: got %h expected 8c880004", instruction_out); end
      checks++; if (pc_seq_out !== 32'h0040_0004) begin errors++; $display("FAIL lw_pc: got %h expected 00400004", pc_seq_out); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b expected 1", valid_out); end
      checks++; if (imm_out !== 32'h0000_0004) begin errors++; $display("FAIL lw_imm: got %h expected 00000004", imm_out); end
      checks++; if (bundle_out !== 24'h000005) begin errors++; $display("FAIL lw_bundle: got %h expected 000005", bundle_out); end
   endtask

   task automatic test_regfile();
      present(32'h0120_5020, 24'h000000, 32'h0040_0008);  // add $10,$9,$0
      tick();
      wb_we_in = 1; wb_addr_in = 5'd9; wb_data_in = 32'hDEAD_BEEF;
      #1;
      checks++; if (rs_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rf_bypass: got %h expected deadbeef", rs_data_out); end
      tick();
      wb_we_in = 0;
      #1;
      checks++; if (rs_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rf_stored: got %h expected deadbeef", rs_data_out); end
      wb_we_in = 1; wb_addr_in = 5'd0; wb_data_in = 32'h0000_1234;
      #1;
      checks++; if (rt_data_out !== 32'h0) begin errors++; $display("FAIL rf_zero_bypass: got %h expected 0", rt_data_out); end
      tick();
      wb_we_in = 0;
      #1;
      checks++; if (rt_data_out !== 32'h0) begin errors++; $display("FAIL rf_zero_write: got %h expected 0", rt_data_out); end
      wb_we_in = 1; wb_addr_in = 5'd5; wb_data_in = 32'h0000_0055;
      #1;
      checks++; if (rs_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rf_other_addr: got %h expected deadbeef", rs_data_out); end
      tick();
      wb_we_in = 0;
   endtask

   task automatic test_hazard();
      present(32'h0103_5020, 24'h000123, 32'h0040_0010);  // add $10,$8,$3
      tick();
      checks++; if (hazard_stall_out !== 1'b0) begin errors++; $display("FAIL hz_idle: got %b expected 0", hazard_stall_out); end
      ex_load_in = 1; ex_dest_in = 5'd8;
      present(32'h3C0B_1234, 24'h000456, 32'h0040_0014);
      #1;
      checks++; if (hazard_stall_out !== 1'b1) begin errors++; $display("FAIL hz_rs: got %b expected 1", hazard_stall_out); end
      checks++; if (bundle_out !== NOP_B) begin errors++; $display("FAIL hz_bubble_bundle: got %h expected %h", bundle_out, NOP_B); end
      checks++; if (instruction_out !== NOP_I) begin errors++; $display("FAIL hz_bubble_instr: got %h expected %h", instruction_out, NOP_I); end
      tick();
      ex_load_in = 0;
      #1;
      checks++; if (instruction_out !== 32'h0103_5020) begin errors++; $display("FAIL hz_reissue: got %h expected 01035020", instruction_out); end
      checks++; if (pc_seq_out !== 32'h0040_0010) begin errors++; $display("FAIL hz_pc_held: got %h expected 00400010", pc_seq_out); end
      checks++; if (hazard_stall_out !== 1'b0) begin errors++; $display("FAIL hz_clear: got %b expected 0", hazard_stall_out); end
      tick();
      checks++; if (instruction_out !== 32'h3C0B_1234) begin errors++; $display("FAIL hz_next: got %h expected 3c0b1234", instruction_out); end
      // rt of an R-type counts
      present(32'h0103_5020, 24'h000123, 32'h0040_0018);
      tick();
      ex_load_in = 1; ex_dest_in = 5'd3;
      #1;
      checks++; if (hazard_stall_out !== 1'b1) begin errors++; $display("FAIL hz_rt: got %b expected 1", hazard_stall_out); end
      ex_load_in = 0;
      // destination $0 never hazards
      present(32'h0003_5020, 24'h000000, 32'h0040_001C);  // add $10,$0,$3
      tick();
      ex_load_in = 1; ex_dest_in = 5'd0;
      #1;
      checks++; if (hazard_stall_out !== 1'b0) begin errors++; $display("FAIL hz_dest0: got %b expected 0", hazard_stall_out); end
      ex_load_in = 0;
      // ori does not read rt
      present(32'h3489_0007, 24'h000000, 32'h0040_0020);  // ori $9,$4,7
      tick();
      ex_load_in = 1; ex_dest_in = 5'd9;
      #1;
      checks++; if (hazard_stall_out !== 1'b0) begin errors++; $display("FAIL hz_ori_rt: got %b expected 0", hazard_stall_out); end
      ex_dest_in = 5'd4;
      #1;
      checks++; if (hazard_stall_out !== 1'b1) begin errors++; $display("FAIL hz_ori_rs: got %b expected 1", hazard_stall_out); end
      ex_load_in = 0; ex_dest_in = 5'd0;
   endtask

   task automatic test_stall_flush();
      stall_in = 1;
      present(32'h1111_1111, 24'h000777, 32'h0040_0024);
      tick();
      checks++; if (instruction_out !== 32'h3489_0007 || pc_seq_out !== 32'h0040_0020) begin errors++; $display("FAIL stall_hold: got %h/%h expected 34890007/00400020", instruction_out, pc_seq_out); end
      flush_in = 1;
      tick();
      flush_in = 0; stall_in = 0;
      #1;
      checks++; if (instruction_out !== NOP_I) begin errors++; $display("FAIL flush_instr: got %h expected %h", instruction_out, NOP_I); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", valid_out); end
      checks++; if (hazard_stall_out !== 1'b0) begin errors++; $display("FAIL flush_hazard: got %b expected 0", hazard_stall_out); end
      checks++; if (pc_seq_out !== 32'h0040_0020) begin errors++; $display("FAIL flush_pc: got %h expected 00400020", pc_seq_out); end
   endtask

   task automatic test_imm();
      present(32'h2009_8000, 24'h000000, 32'h0040_0028);
      tick();
      checks++; if (imm_out !== 32'hFFFF_8000) begin errors++; $display("FAIL imm_sign: got %h expected ffff8000", imm_out); end
      present(32'h2009_8000, 24'h080000, 32'h0040_002C);
      tick();
      checks++; if (imm_out !== 32'h0000_8000) begin errors++; $display("FAIL imm_zero: got %h expected 00008000", imm_out); end
   endtask

   task automatic test_reset_mid_stall();
      present(32'h0103_5020, 24'h000123, 32'h0040_0030);
      tick();
      ex_load_in = 1; ex_dest_in = 5'd8;
      #1;
      checks++; if (hazard_stall_out !== 1'b1) begin errors++; $display("FAIL rst_hz_pre: got %b expected 1", hazard_stall_out); end
      reset = 1;
      tick();
      reset = 0;
      #1;
      checks++; if (instruction_out !== NOP_I || valid_out !== 1'b0 || hazard_stall_out !== 1'b0) begin errors++; $display("FAIL rst_hz_clear: got %h v=%b h=%b expected %h v=0 h=0", instruction_out, valid_out, hazard_stall_out, NOP_I); end
      checks++; if (pc_seq_out !== RST_PC) begin errors++; $display("FAIL rst_hz_pc: got %h expected %h", pc_seq_out, RST_PC); end
      ex_load_in = 0;
      present(32'h0120_5020, 24'h000000, 32'h0040_0004);
      tick();
      checks++; if (rs_data_out !== 32'h0) begin errors++; $display("FAIL rst_rf_cleared: got %h expected 0", rs_data_out); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_regfile();
      test_hazard();
      test_stall_flush();
      test_imm();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Stage directly downstream of the fetch stage.
- Holds the IF/ID pipeline register for the 32-bit instruction, the 24-bit control bundle and the sequential PC (pc+4).
- Contains the 32x32 register file with write-through bypass, and produces the extended immediate.
- Detects load-use hazards: on a hazard it freezes fetch and itself for one cycle and sends a NOP bubble to execute.

Parameters:
- W_BUNDLE, 24, width of the control bundle.
- RESET_PC, 32'h00400000, pc_seq value after reset.
- NOP_INSTR, 32'h34000000, bubble instruction (ori $zero,$zero,0).
- NOP_BUNDLE, 24'h0E2531, control bundle paired with NOP_INSTR.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- instruction_in  in  32  instruction from fetch.
- bundle_in  in  W_BUNDLE  control bundle from fetch.
- pc_seq_in  in  32  pc+4 from fetch.
- stall_in  in  1  external stall; hold the IF/ID register.
- flush_in  in  1  taken branch/jump; squash the IF/ID contents.
- wb_we_in  in  1  register-file write enable from writeback.
- wb_addr_in  in  5  write register number.
- wb_data_in  in  32  write data.
- ex_load_in  in  1  instruction now in execute is a load.
- ex_dest_in  in  5  destination register of that instruction.
- instruction_out  out  32  instruction to execute (NOP_INSTR when bubbling).
- bundle_out  out  W_BUNDLE  bundle to execute (NOP_BUNDLE when bubbling).
- pc_seq_out  out  32  registered pc+4.
- rs_data_out  out  32  register-file read of instr[25:21].
- rt_data_out  out  32  register-file read of instr[20:16].
- imm_out  out  32  extended instr[15:0].
- hazard_stall_out  out  1  load-use stall; fetch must de-assert its PC enable.
- valid_out  out  1  IF/ID holds a real (non-squashed) instruction.

Behaviour:
- IF/ID register update, evaluated each rising edge in priority order:
  - reset: instr=NOP_INSTR, bundle=NOP_BUNDLE, pc_seq=RESET_PC, valid=0.
  - flush_in: load NOP_INSTR/NOP_BUNDLE, valid=0, pc_seq unchanged. Flush wins over any stall.
  - stall_in or hazard_stall_out: hold all fields.
  - otherwise: load the *_in values, valid=1.
- Latency: an instruction presented at edge N appears on the outputs after edge N (one cycle).
- Load-use hazard (combinational, from registered instr):
  - rs = instr[25:21], rt = instr[20:16].
  - uses_rt = 1 when opcode is 0x00, 0x04, 0x05, 0x28, 0x29 or 0x2B.
  - hazard_stall_out = ex_load_in & valid & (ex_dest_in != 0) & ((ex_dest_in == rs) | (uses_rt & ex_dest_in == rt)).
  - While hazard_stall_out=1: instruction_out=NOP_INSTR and bundle_out=NOP_BUNDLE (bubble). The register holds, so the consuming instruction re-issues the next cycle, once the load has left execute.
  - When valid=0, hazard_stall_out is forced to 0.
- Register file:
  - 32 x 32 bits; register 0 always reads 0 and writes to it are ignored.
  - Write is synchronous at the edge when wb_we_in=1 and wb_addr_in!=0.
  - Read is combinational with write-through bypass: if wb_we_in=1, wb_addr_in==read address and address!=0, return wb_data_in in the same cycle.
  - Synchronous reset clears all 32 entries to 0.
  - Register-file writes proceed regardless of stall, flush or hazard.
- Immediate:
  - bundle[19] (extender select) = 1: imm_out = {16'h0, instr[15:0]} (zero-extend).
  - bundle[19] = 0: imm_out = sign-extended instr[15:0].
- Output reset values: instruction_out=NOP_INSTR, bundle_out=NOP_BUNDLE, pc_seq_out=RESET_PC, rs_data_out=0, rt_data_out=0, imm_out=0, hazard_stall_out=0, valid_out=0.
- Reset asserted mid-stall: the next edge clears everything, and the hazard/stall hold is abandoned.

Test Plan:
- Reset, then present instruction_in=0x8C880004 (lw $8,4($4)), bundle_in=0x000005, pc_seq_in=0x00400004. Required after one edge: instruction_out=0x8C880004, pc_seq_out=0x00400004, valid_out=1, imm_out=0x00000004.
- Write $9=0xDEADBEEF via writeback; an instruction with rs=9 reads 0xDEADBEEF in that same cycle (bypass) and on later cycles. A write to $0 with 0x1234 -> $0 still reads 0.
- IF/ID holds add $10,$8,$3 (0x01035020) with ex_load_in=1, ex_dest_in=8. Required: hazard_stall_out=1, bundle_out=NOP_BUNDLE, register held one cycle. With ex_load_in=0 next cycle -> add issues and hazard_stall_out=0.
- Same case with ex_dest_in=0 -> no hazard. An ori (opcode 0x0D, rt not used) with ex_dest_in equal to its rt -> no hazard.
- flush_in=1 and stall_in=1 in the same cycle -> next cycle instruction_out=NOP_INSTR, valid_out=0, hazard_stall_out=0.
- imm 0x8000 with bundle[19]=0 -> imm_out=0xFFFF8000. The same immediate with bundle[19]=1 -> imm_out=0x00008000.
